sync_req_arbiter: RTL

Round-robin arbiter that grants one shared resource to up to NUM_REQ requesters whose request lines arrive asynchronously to `clk`. Each request line passes through an internal reset-to-0 multi-flop synchronizer and a rising-edge detector, then a pending latch. A three-state FSM issues a one-hot grant, holds it until the requester reports `done`, and inserts a one-cycle release gap. The block sits between off-clock-domain request sources (buttons, external handshakes) and a single-ported datapath resource.

---
 rtl/sync_req_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for async request lines: synchronizer, rise detect, pending latch, grant FSM.
// Async-to-grant latency SYNC_STAGES+2 edges; grant held until done, then a one-cycle release gap.
module sync_req_arbiter #(
   parameter  int NUM_REQ     = 4,
   parameter  int SYNC_STAGES = 2,
   localparam int IDW         = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] async_req,
   input  logic               done,
   output logic [NUM_REQ-1:0] sync_req,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [IDW-1:0]     grant_id
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t             state;
   logic [NUM_REQ-1:0] sync_ff [SYNC_STAGES];
   logic [NUM_REQ-1:0] sync_req_d;
   logic [NUM_REQ-1:0] rise;
   logic [NUM_REQ-1:0] pend;
   logic [NUM_REQ-1:0] win_oh;
   logic [NUM_REQ-1:0] pend_clr;
   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     win_idx;
   logic               win_found;
   logic               take;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '0;
      end else begin
         sync_ff[0] <= async_req;
         for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
      end
   end

   assign sync_req = sync_ff[SYNC_STAGES-1];
   assign rise     = sync_req & ~sync_req_d;

   // First pending index at or after ptr, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!win_found && pend[idx]) begin
            win_found = 1'b1;
            win_idx   = IDW'(idx);
         end
      end
   end

   assign win_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
   assign take     = (state == IDLE) && win_found;
   assign pend_clr = take ? win_oh : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sync_req_d  <= '0;
         pend        <= '0;
         ptr         <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
      end else begin
         sync_req_d <= sync_req;
         // A rise landing on the grant edge survives the clear.
         pend       <= (pend & ~pend_clr) | rise;
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant       <= win_oh;
                  grant_valid <= 1'b1;
                  grant_id    <= win_idx;
                  state       <= GRANT;
               end
            end
            GRANT: begin
               if (done) begin
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  grant_id    <= '0;
                  ptr         <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);
                  state       <= RELEASE;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
